// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
interface cla_pipe_addsub_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  cin;
    logic                  sub;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] sum;
    logic                  cout;
    logic                  ovf;
    logic                  zero;
    logic [TAG_WIDTH-1:0]  tag_out;

    modport master (
        output in_valid, A, B, cin, sub, tag_in, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );

    modport slave (
        input  in_valid, A, B, cin, sub, tag_in, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one CLA segment per stage, carry
// handed stage to stage through registers, valid/ready with per-stage backpressure.
module cla_seg #(
    parameter int W  = 16,
    parameter int BW = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_top
);
    localparam int NG = W / BW;

    logic [W-1:0]  p, g, c;
    logic [NG-1:0] gg, pg;
    logic [NG:0]   cg;
    logic          t;

    assign p = a ^ b;
    assign g = a & b;

    // Group G/P chain the group carries; bit carries expand from the group carry-in.
    always_comb begin
        gg    = '0;
        pg    = '0;
        cg    = '0;
        c     = '0;
        t     = 1'b0;
        cg[0] = ci;
        for (int k = 0; k < NG; k++) begin
            pg[k] = 1'b1;
            for (int j = 0; j < BW; j++) begin
                gg[k] = g[k*BW+j] | (p[k*BW+j] & gg[k]);
                pg[k] = pg[k] & p[k*BW+j];
            end
            cg[k+1]  = gg[k] | (pg[k] & cg[k]);
            c[k*BW]  = cg[k];
            for (int j = 1; j < BW; j++) begin
                t = cg[k];
                for (int i = 0; i < j; i++)
                    t = g[k*BW+i] | (p[k*BW+i] & t);
                c[k*BW+j] = t;
            end
        end
    end

    assign s     = p ^ c;
    assign co    = cg[NG];
    assign c_top = c[W-1];
endmodule

module cla_pipe_addsub #(
    parameter int DATA_WIDTH  = 64,
    parameter int STAGES      = 4,
    parameter int BLOCK_WIDTH = 4,
    parameter int TAG_WIDTH   = 8
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int SEG = DATA_WIDTH / STAGES;

    if (STAGES < 1 || BLOCK_WIDTH < 1 || (DATA_WIDTH % STAGES) != 0 ||
        ((DATA_WIDTH / STAGES) % BLOCK_WIDTH) != 0) begin : g_param_err
        $error("cla_pipe_addsub: illegal DATA_WIDTH/STAGES/BLOCK_WIDTH combination");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] sum;
        logic                  c;
        logic                  c_top;
        logic [TAG_WIDTH-1:0]  tag;
    } stage_t;

    stage_t                    st_in;
    stage_t                    src   [STAGES:1];
    stage_t                    st_nx [STAGES:1];
    stage_t                    st_q  [STAGES:1];
    logic [STAGES:1]           vld_q;
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:1]           rdy;
    logic                      rdy_acc;
    logic [STAGES:1][SEG-1:0]  seg_sum;
    logic [STAGES:1]           seg_co, seg_top;
    logic                      unused_ok;

    assign vld_pipe = {vld_q, bus.in_valid};

    // Subtraction is folded in here so later stages only ever add.
    always_comb begin
        st_in     = '0;
        st_in.a   = bus.A;
        st_in.b   = bus.sub ? ~bus.B : bus.B;
        st_in.c   = bus.sub | bus.cin;
        st_in.tag = bus.tag_in;
    end

    always_comb begin
        src[1] = st_in;
        for (int s = 2; s <= STAGES; s++)
            src[s] = st_q[s-1];
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_seg
        cla_seg #(.W(SEG), .BW(BLOCK_WIDTH)) u_cla (
            .a     (src[s].a[(s-1)*SEG +: SEG]),
            .b     (src[s].b[(s-1)*SEG +: SEG]),
            .ci    (src[s].c),
            .s     (seg_sum[s]),
            .co    (seg_co[s]),
            .c_top (seg_top[s])
        );
    end

    always_comb begin
        for (int s = 1; s <= STAGES; s++) begin
            st_nx[s]                         = src[s];
            st_nx[s].sum[(s-1)*SEG +: SEG]   = seg_sum[s];
            st_nx[s].c                       = seg_co[s];
            st_nx[s].c_top                   = seg_top[s];
        end
    end

    // A stage can take a beat if it or any stage downstream of it has a free slot.
    always_comb begin
        rdy     = '0;
        rdy_acc = bus.out_ready;
        for (int s = STAGES; s >= 1; s--) begin
            rdy_acc = rdy_acc | ~vld_q[s];
            rdy[s]  = rdy_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 1; s <= STAGES; s++)
                st_q[s] <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (rdy[s]) begin
                    vld_q[s] <= vld_pipe[s-1];
                    if (vld_pipe[s-1])
                        st_q[s] <= st_nx[s];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = vld_q[STAGES];
    assign bus.sum       = st_q[STAGES].sum;
    assign bus.cout      = st_q[STAGES].c;
    assign bus.ovf       = st_q[STAGES].c ^ st_q[STAGES].c_top;
    assign bus.zero      = vld_q[STAGES] && (st_q[STAGES].sum == '0);
    assign bus.tag_out   = st_q[STAGES].tag;

    // Already-summed operand bits and early top carries are dead once passed on.
    always_comb begin
        unused_ok = 1'b0;
        for (int s = 1; s <= STAGES; s++)
            unused_ok = unused_ok ^ (^st_q[s]);
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and randomized checks of cla_pipe_addsub (64 bits, 4 stages, 4-bit groups).
module tb_cla_pipe_addsub;
    localparam int DW = 64;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    cla_pipe_addsub #(
        .DATA_WIDTH(DW), .STAGES(4), .BLOCK_WIDTH(4), .TAG_WIDTH(TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [64:0] res;
        logic        ovf;
        logic [7:0]  tag;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          sent, got, seen;
    logic        pend;
    logic [63:0] ra, rb, bop;
    logic        rc, rs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One isolated beat with out_ready=1; checks the accept-to-valid latency too.
    task automatic do_one(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb, input logic [7:0] tg,
                          input logic [63:0] es, input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        chk({nm, "/in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1; bus.A = a; bus.B = b; bus.cin = ci; bus.sub = sb; bus.tag_in = tg;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0; bus.A = ~a; bus.B = ~b; bus.sub = ~sb; bus.cin = ~ci;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "/early_valid"}, bus.out_valid, 0);
        @(negedge clk);
        chk({nm, "/out_valid"}, bus.out_valid, 1);
        chk({nm, "/sum"}, bus.sum, es);
        chk({nm, "/cout"}, bus.cout, ec);
        chk({nm, "/ovf"}, bus.ovf, eo);
        chk({nm, "/zero"}, bus.zero, ez);
        chk({nm, "/tag"}, bus.tag_out, tg);
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.cin = 0; bus.sub = 0;
        bus.tag_in = 0; bus.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/sum", bus.sum, 0);
        chk("rst/cout", bus.cout, 0);
        chk("rst/ovf", bus.ovf, 0);
        chk("rst/zero", bus.zero, 0);
        chk("rst/tag", bus.tag_out, 0);
        rst = 0;
        @(negedge clk);
        chk("rst/in_ready", bus.in_ready, 1);

        do_one("allones_cin", '1, '1, 1, 0, 8'h11, '1, 1, 0, 0);
        do_one("ripple", '1, 64'd1, 0, 0, 8'h22, 64'd0, 1, 0, 1);
        do_one("sub_neg", 64'd5, 64'd7, 0, 1, 8'h33, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        do_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 0, 1, 8'h44,
               64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
        do_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 8'h55,
               64'h8000_0000_0000_0000, 0, 1, 0);
        do_one("sub_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1, 1, 8'h66,
               64'd0, 1, 0, 1);
        do_one("seg_carry", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1, 0, 8'h77,
               64'h0001_0000_0000_0000, 0, 0, 0);

        // Ten back-to-back beats against a 6-cycle output stall.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 6);
            if (sent < 10) begin
                bus.in_valid = 1; bus.A = 64'(sent); bus.B = 64'd100;
                bus.cin = 0; bus.sub = 0; bus.tag_in = 8'(sent);
            end else begin
                bus.in_valid = 0;
            end
            #1;
            if (cyc == 5) begin
                chk("stall/accepted", sent, 4);
                chk("stall/in_ready", bus.in_ready, 0);
                chk("stall/hold_sum", bus.sum, 64'd100);
                chk("stall/hold_tag", bus.tag_out, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("stream/tag", bus.tag_out, got);
                chk("stream/sum", bus.sum, 64'(got + 100));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
        end
        chk("stream/count", got, 10);
        @(negedge clk);
        bus.in_valid = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("stream/no_dup", seen, 0);

        // Reset with three beats in flight.
        bus.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1; bus.A = 64'h0101 * 64'(k + 1); bus.B = 64'h10;
            bus.cin = 0; bus.sub = 0; bus.tag_in = 8'(8'h40 + k);
            @(negedge clk);
        end
        bus.in_valid = 0;
        @(negedge clk);
        chk("flight/out_valid", bus.out_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst/out_valid", bus.out_valid, 0);
        chk("arst/sum", bus.sum, 0);
        chk("arst/tag", bus.tag_out, 0);
        chk("arst/cout", bus.cout, 0);
        @(negedge clk);
        rst = 0;
        bus.out_ready = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("arst/no_stale", seen, 0);
        chk("arst/in_ready", bus.in_ready, 1);

        // Random operands, random backpressure, in-order scoreboard.
        sent = 0; got = 0; pend = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            @(negedge clk);
            if (!pend && sent < 1000) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0: rb = ~ra;
                    1: ra = '1;
                    default: ;
                endcase
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                bus.in_valid = 1; bus.A = ra; bus.B = rb; bus.cin = rc; bus.sub = rs;
                bus.tag_in = 8'(sent);
                pend = 1;
            end else if (!pend) begin
                bus.in_valid = 0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd/unexpected", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd/res", {bus.cout, bus.sum}, e.res);
                    chk("rnd/ovf", bus.ovf, e.ovf);
                    chk("rnd/tag", bus.tag_out, e.tag);
                    chk("rnd/zero", bus.zero, e.res[63:0] == 64'd0);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                bop   = rs ? ~rb : rb;
                e.res = {1'b0, ra} + {1'b0, bop} + 65'(rs ? 1'b1 : rc);
                e.ovf = (ra[63] == bop[63]) && (e.res[63] != ra[63]);
                e.tag = 8'(sent);
                q.push_back(e);
                sent++;
                pend = 0;
            end
            @(posedge clk);
        end
        chk("rnd/count", got, 1000);
        @(negedge clk);
        bus.in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
